// File: rtl/w_rom_rd_sched_if.sv
// Request, stream-control and ROM-port signals of the weight-ROM read scheduler.
// The master side holds the requesters and the consumer; the slave side is the scheduler.
interface w_rom_rd_sched_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  s_req;
    logic [ADDR_WIDTH-1:0] s_base;
    logic [ADDR_WIDTH:0]   s_len;
    logic                  s_rdy;
    logic                  s_ack;
    logic                  s_done;
    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_ack;
    logic                  rom_cen_b;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rd_valid;
    logic                  rd_src;
    logic                  rd_last;

    modport master (
        output s_req, s_base, s_len, s_rdy, d_req, d_addr,
        input  s_ack, s_done, d_ack, rom_cen_b, rom_addr, rd_valid, rd_src, rd_last
    );

    modport slave (
        input  s_req, s_base, s_len, s_rdy, d_req, d_addr,
        output s_ack, s_done, d_ack, rom_cen_b, rom_addr, rd_valid, rd_src, rd_last
    );
endinterface

// File: rtl/w_rom_rd_sched.sv
// Shares one weight-ROM read port between streaming bursts and single debug reads,
// and tags each returned word (after ROM_LATENCY cycles) with source and last-of-burst.
module w_rom_rd_sched #(
    parameter int unsigned DATA_DEPTH  = 512,
    parameter int unsigned ADDR_WIDTH  = $clog2(DATA_DEPTH),
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    w_rom_rd_sched_if.slave  bus
);
    localparam int unsigned LEN_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]       left_q, left_d;
    logic [ADDR_WIDTH-1:0]  hold_q;
    logic                   zdone_q, zdone_d;
    logic [ROM_LATENCY-1:0] pv_q, ps_q, pl_q;

    logic                   iss;
    logic                   iss_src;
    logic                   iss_last;
    logic [ADDR_WIDTH-1:0]  iss_addr;
    logic                   s_ack_w;
    logic                   d_ack_w;
    logic                   pipe_done;
    logic                   s_done_w;

    assign pipe_done = pv_q[ROM_LATENCY-1] & ~ps_q[ROM_LATENCY-1] & pl_q[ROM_LATENCY-1];
    assign s_done_w  = pipe_done | zdone_q;

    // Acks and issues are decided in the request cycle so a level request is
    // consumed exactly once; iss_addr doubles as the held address when idle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        zdone_d  = 1'b0;
        iss      = 1'b0;
        iss_src  = 1'b0;
        iss_last = 1'b0;
        iss_addr = hold_q;
        s_ack_w  = 1'b0;
        d_ack_w  = 1'b0;

        case (state_q)
            BURST: begin
                if (bus.s_rdy) begin
                    iss      = 1'b1;
                    iss_addr = addr_q;
                    iss_last = (left_q == LEN_W'(1));
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    left_d   = left_q - LEN_W'(1);
                    if (left_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end else if (bus.d_req) begin
                    iss      = 1'b1;
                    iss_src  = 1'b1;
                    iss_addr = bus.d_addr;
                    d_ack_w  = 1'b1;
                end
            end
            IDLE, DRAIN: begin
                if (bus.d_req) begin
                    iss      = 1'b1;
                    iss_src  = 1'b1;
                    iss_addr = bus.d_addr;
                    d_ack_w  = 1'b1;
                end else if (state_q == IDLE && bus.s_req) begin
                    s_ack_w = 1'b1;
                    addr_d  = bus.s_base;
                    left_d  = bus.s_len;
                    if (bus.s_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
                if (state_q == DRAIN && s_done_w) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_b) begin
            iss      = 1'b0;
            iss_src  = 1'b0;
            iss_last = 1'b0;
            iss_addr = '0;
            s_ack_w  = 1'b0;
            d_ack_w  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            hold_q  <= '0;
            zdone_q <= 1'b0;
            pv_q    <= '0;
            ps_q    <= '0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            hold_q  <= iss_addr;
            zdone_q <= zdone_d;
            pv_q    <= ROM_LATENCY'({pv_q, iss});
            ps_q    <= ROM_LATENCY'({ps_q, iss_src});
            pl_q    <= ROM_LATENCY'({pl_q, iss_last});
        end
    end

    assign bus.rom_cen_b = ~iss;
    assign bus.rom_addr  = iss_addr;
    assign bus.s_ack     = s_ack_w;
    assign bus.d_ack     = d_ack_w;
    assign bus.s_done    = ~rst_b & s_done_w;
    assign bus.rd_valid  = ~rst_b & pv_q[ROM_LATENCY-1];
    assign bus.rd_src    = ~rst_b & ps_q[ROM_LATENCY-1];
    assign bus.rd_last   = ~rst_b & pl_q[ROM_LATENCY-1];
endmodule

// File: doc/w_rom_rd_sched.md
# w_rom_rd_sched

Read scheduler for a weight-ROM bank in the B-CEDNet datapath. It shares the bank's single read port between two requesters: the layer engine's streaming burst reads and a single-word debug/readback port. It drives the bank's active-low chip enable and address, and tracks the fixed ROM read latency. Each returned word is tagged with its source and a last-of-burst flag, so downstream logic can capture the wide weight word directly from the bank output.

## Interface
Parameters:
- DATA_DEPTH, 512, words per ROM bank; must be a power of two.
- ADDR_WIDTH, $clog2(DATA_DEPTH), ROM address width.
- ROM_LATENCY, 1, cycles from the enable/address cycle to valid data on the bank output; range 1–4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_b  in  1  reset, synchronous, active-high (1 = reset).
- s_req  in  1  stream burst request; level, held until s_ack.
- s_base  in  ADDR_WIDTH  burst start address; sampled at s_ack.
- s_len  in  ADDR_WIDTH+1  burst word count, 0..DATA_DEPTH; sampled at s_ack.
- s_rdy  in  1  stream consumer ready; 0 pauses burst issue.
- s_ack  out  1  one-cycle pulse: burst accepted.
- s_done  out  1  one-cycle pulse: burst fully returned.
- d_req  in  1  debug single-read request; level, held until d_ack.
- d_addr  in  ADDR_WIDTH  debug read address; sampled at d_ack.
- d_ack  out  1  one-cycle pulse: debug read issued this cycle.
- rom_cen_b  out  1  ROM chip enable, active-low.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rd_valid  out  1  bank output holds a returned word this cycle.
- rd_src  out  1  source of the returned word: 0 = stream, 1 = debug.
- rd_last  out  1  returned word is the final word of a stream burst.

## Operation
- States:
  - IDLE: no burst active.
  - BURST: burst words remaining to issue.
  - DRAIN: all burst words issued; waiting for the final word to return.
- IDLE:
  - d_req has priority. When d_req=1: issue the debug read and assert d_ack the same cycle; stream request is not accepted.
  - Otherwise, when s_req=1: assert s_ack, load the address counter with s_base and the remaining count with s_len.
  - If s_len=0: pulse s_done on the cycle after s_ack, issue no reads, stay in IDLE.
  - If s_len>0: go to BURST.
- BURST, each cycle:
  - If s_rdy=1: issue the stream read at the current address, increment the address modulo DATA_DEPTH, decrement the remaining count.
  - If s_rdy=0 and d_req=1: issue the debug read and assert d_ack.
  - After the last stream word is issued, go to DRAIN.
- DRAIN:
  - d_req is served exactly as in IDLE.
  - s_req is not accepted.
  - Go to IDLE on the cycle s_done pulses.
- Issue cycle: rom_cen_b=0, rom_addr = the issued address. Non-issue cycles: rom_cen_b=1, rom_addr holds its last value.
- Return tracking: a ROM_LATENCY-deep shift register carries {valid, src, last} for each issue, producing rd_valid, rd_src and rd_last.
- s_done = rd_valid & ~rd_src & rd_last.
- Consumer rule: after s_rdy falls, up to ROM_LATENCY stream words already issued still return. The consumer must absorb them.
- Address wrap: s_base=DATA_DEPTH-2 with s_len=4 issues DATA_DEPTH-2, DATA_DEPTH-1, 0, 1.
- s_len=DATA_DEPTH reads every word exactly once.

## Timing
- Reset values:
  - rom_cen_b=1, rom_addr=0.
  - s_ack, s_done, d_ack, rd_valid, rd_src, rd_last all 0.
  - State IDLE; return pipeline cleared.
- Reset mid-burst: the burst is aborted. No rd_valid and no s_done appear from reads issued before reset.
- Debug read latency: d_ack and the issue occur in the same cycle, N. rd_valid with rd_src=1 appears in cycle N+ROM_LATENCY.
- Stream latency:
  - s_ack in cycle N; first issue no earlier than N+1.
  - With s_rdy held at 1, word k issues in cycle N+1+k.
  - s_done occurs in cycle N+len+ROM_LATENCY.
- Peak throughput: one read per cycle.
- A second burst is accepted no earlier than the cycle after s_done.
- Simultaneous d_req and s_req in IDLE: the debug read is served first. s_ack follows in the next cycle if s_req is still held and d_req has dropped.

## Test plan
- Debug read: IDLE, d_req=1, d_addr=5, ROM_LATENCY=1. Required: same cycle d_ack=1, rom_cen_b=0, rom_addr=5; next cycle rd_valid=1, rd_src=1, rd_last=0.
- Wrapping burst: s_base=510, s_len=4, s_rdy=1. Required: s_ack pulse; rom_addr 510, 511, 0, 1 on four consecutive cycles; rd_last only on the 4th return; s_done on that same cycle.
- Paused burst with debug insertion: s_len=3, s_rdy pattern 1,0,1,1 with d_req=1, d_addr=7 during the low cycle. Required: issue sequence stream, debug(7), stream, stream; return tags 0,1,0,0; one s_done.
- Simultaneous requests and zero length: d_req and s_req together in IDLE → d_ack first, s_ack the next cycle. Separately, s_len=0 → s_done one cycle after s_ack, rom_cen_b stays 1 throughout.
- Reset mid-burst: s_len=8, assert rst_b after 3 issues. Required: the following cycle rom_cen_b=1; no rd_valid or s_done afterwards; a new burst with s_base=0, s_len=2 then completes normally.
- Full-depth latency sweep: ROM_LATENCY=3, s_len=512. Required: 512 returns with no gaps, each word returned exactly once; s_done in cycle N+515.
